// File: rtl/egress_buffer.sv
// egress_buffer: per-output-port egress buffer behind a crossbar.
// A scheduler grant (en/sel) is registered for one cycle while the granted
// input FIFO presents its word on q1..q3; the word is then pushed into a
// circular buffer drained by out_valid/out_ready.
// Optional feature: define EGRESS_BUFFER_DROP_CNT_EN to add a saturating
// 16-bit drop_cnt output counting pushes discarded while full.
module egress_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [1:0]               sel,
  input  logic [DATA_W-1:0]        q1,
  input  logic [DATA_W-1:0]        q2,
  input  logic [DATA_W-1:0]        q3,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
`ifdef EGRESS_BUFFER_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  logic              pend_v;
  logic [1:0]        pend_sel;
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] push_word;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              drop;

  // Stage 1: capture the grant while the granted FIFO produces its word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v   <= 1'b0;
      pend_sel <= 2'b00;
    end else begin
      pend_v   <= en;
      pend_sel <= sel;
    end
  end

  // Stage 2: pick the granted FIFO's word and decide push/pop/drop
  always_comb begin
    push_word = '0;
    case (pend_sel)
      2'b01:   push_word = q1;
      2'b10:   push_word = q2;
      2'b11:   push_word = q3;
      default: push_word = '0;
    endcase
    push_req = pend_v && (pend_sel != 2'b00);
    pop      = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // Buffer storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  // Circular pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef EGRESS_BUFFER_DROP_CNT_EN
  // Saturating count of pushes discarded because the buffer was full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign level     = wr_ptr - rd_ptr;
  assign full      = (level == LEVEL_FULL);
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_egress_buffer.sv
// tb_egress_buffer: randomized and directed stimulus for egress_buffer,
// compared every cycle against a queue-based reference of the buffer.
module tb_egress_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [1:0]        sel;
  logic [DATA_W-1:0] q1, q2, q3;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     level;
  logic              full;
`ifdef EGRESS_BUFFER_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  egress_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sel       (sel),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full)
`ifdef EGRESS_BUFFER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference: words in arrival order, the grant seen on the previous edge,
  // and the number of discarded pushes.
  logic [DATA_W-1:0] mq[$];
  logic              g_en;
  logic [1:0]        g_sel;
  int unsigned       drops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    g_en  = 1'b0;
    g_sel = 2'b00;
    drops = 0;
  endtask

  task automatic model_edge();
    logic [DATA_W-1:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if ((mq.size() != 0) && out_ready) w = mq.pop_front();
    if (g_en && (g_sel != 2'b00)) begin
      w = (g_sel == 2'd1) ? q1 : (g_sel == 2'd2) ? q2 : q3;
      if (mq.size() < DEPTH) mq.push_back(w);
      else if (drops < 32'hFFFF) drops++;
    end
    g_en  = en;
    g_sel = sel;
  endtask

  task automatic compare();
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("level", 32'(level), 32'(mq.size()));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
`ifdef EGRESS_BUFFER_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), drops);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic e, input logic [1:0] s, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c, input logic r);
    en = e; sel = s; q1 = a; q2 = b; q3 = c; out_ready = r;
  endtask

  function automatic logic [DATA_W-1:0] rnd();
    return DATA_W'($urandom);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 2'b00, '0, '0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    do_reset();
    check("reset_level", 32'(level), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);

    // Single grant from port 1 appears after two edges
    drive(1'b1, 2'b01, rnd(), rnd(), rnd(), 1'b0);
    step();
    drive(1'b0, 2'b00, 8'h55, rnd(), rnd(), 1'b0);
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h55);
    check("single_level", 32'(level), 32'd1);
    drive(1'b0, 2'b00, rnd(), rnd(), rnd(), 1'b1);
    step();

    // Back-to-back grants from all three ports keep their order
    drive(1'b1, 2'b01, rnd(), rnd(), rnd(), 1'b0);
    step();
    drive(1'b1, 2'b10, 8'hA1, rnd(), rnd(), 1'b0);
    step();
    drive(1'b1, 2'b11, rnd(), 8'hB2, rnd(), 1'b0);
    step();
    drive(1'b0, 2'b00, rnd(), rnd(), 8'hC3, 1'b0);
    step();
    check("b2b_level", 32'(level), 32'd3);
    check("b2b_first", 32'(out_data), 32'hA1);
    drive(1'b0, 2'b00, rnd(), rnd(), rnd(), 1'b1);
    step();
    check("b2b_second", 32'(out_data), 32'hB2);
    step();
    check("b2b_third", 32'(out_data), 32'hC3);
    step();

    // Nine pushes into an eight-entry buffer: the last one is dropped
    for (int i = 0; i <= 9; i++) begin
      drive(i < 9, 2'b01, (i == 0) ? rnd() : DATA_W'(i - 1), rnd(), rnd(), 1'b0);
      step();
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_level", 32'(level), 32'd8);
    check("fill_head", 32'(out_data), 32'h00);
`ifdef EGRESS_BUFFER_DROP_CNT_EN
    check("fill_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Push while full with a simultaneous pop
    drive(1'b1, 2'b10, rnd(), rnd(), rnd(), 1'b0);
    step();
    drive(1'b0, 2'b00, rnd(), 8'h77, rnd(), 1'b1);
    step();
    check("fullpp_level", 32'(level), 32'd8);
    for (int i = 0; i < 7; i++) step();
    check("fullpp_last", 32'(out_data), 32'h77);
    step();
    check("drained", 32'(out_valid), 32'd0);

    // Twenty pushes with continuous draining: pointers wrap
    for (int i = 0; i < 21; i++) begin
      drive(i < 20, 2'(1 + $urandom_range(0, 2)), rnd(), rnd(), rnd(), 1'b1);
      step();
    end
    step();

    // Grant captured just before reset must never be written
    drive(1'b1, 2'b01, rnd(), rnd(), rnd(), 1'b0);
    step();
    drive(1'b0, 2'b00, rnd(), rnd(), rnd(), 1'b0);
    do_reset();
    step();
    check("rstgrant_level", 32'(level), 32'd0);
    check("rstgrant_valid", 32'(out_valid), 32'd0);

    // Random traffic: fill-biased then drain-biased phases, one mid-run reset
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 60; i++) begin
        drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rnd(), rnd(), rnd(),
              (ph % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        step();
      end
      if (ph == 2) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/egress_buffer.md
EGRESS_BUFFER -- requirements
Module: egress_buffer

Interface
REQ-001 Parameter DATA_W, default 8, packet word width (bits [1:0] carry destination port).
REQ-002 Parameter DEPTH, default 8, buffer entries; power of two, 2..64.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  grant pulse from crossbar scheduler for this output port.
REQ-006 sel  input  2  granted input port: 01=port1, 10=port2, 11=port3, 00=none.
REQ-007 q1, q2, q3  input  DATA_W each  read data of input FIFOs 1..3, valid one cycle after rdreq.
REQ-008 out_data  output  DATA_W  head-of-buffer word.
REQ-009 out_valid  output  1  buffer non-empty.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 level  output  log2(DEPTH)+1  current occupancy.
REQ-012 full  output  1  level == DEPTH.

Function
REQ-013 Stage 1 SHALL register en and sel into pend_v/pend_sel on every clock edge.
REQ-014 Stage 2 SHALL, when pend_v=1, select q1/q2/q3 per pend_sel and push the word; pend_sel=00 SHALL push nothing.
REQ-015 Latency: en at edge N -> word written at edge N+1 -> out_valid visible after edge N+1 if buffer was empty.
REQ-016 en on consecutive cycles SHALL produce consecutive pushes, no bubble, no loss.
REQ-017 Buffer SHALL be circular: wr_ptr/rd_ptr log2(DEPTH)+1 bits, wrap modulo 2*DEPTH, MSB distinguishes full from empty.
REQ-018 Pop SHALL occur when out_valid && out_ready; rd_ptr increments by 1.
REQ-019 Push when full and no simultaneous pop SHALL be dropped; buffer, pointers, level unchanged.
REQ-020 Push and pop in same cycle when full SHALL both succeed; level stays DEPTH.
REQ-021 Push and pop same cycle when non-full SHALL leave level unchanged.
REQ-022 out_ready with out_valid=0 SHALL have no effect.
REQ-023 out_data SHALL equal mem[rd_ptr] combinationally; out_data when out_valid=0 is don't-care.
REQ-024 FIFO order SHALL be preserved across wrap-around.
REQ-025 level SHALL equal wr_ptr - rd_ptr (modulo 2*DEPTH); full and out_valid derived from level.

Reset
REQ-026 rst_n low SHALL immediately clear pend_v, pend_sel, wr_ptr, rd_ptr (and drop_cnt if present).
REQ-027 Outputs during/after reset: out_valid=0, level=0, full=0, out_data=don't-care.
REQ-028 A grant registered in stage 1 when reset asserts SHALL be discarded, never written.
REQ-029 Memory contents need not be reset.

Configuration
REQ-030 Macro EGRESS_BUFFER_DROP_CNT_EN defined: add output drop_cnt (16 bits), incremented per dropped push (REQ-019), saturating at 0xFFFF, cleared by reset.
REQ-031 Macro undefined: no drop_cnt port or logic; drop behaviour otherwise identical.

Verification
REQ-032 Reset, en=1 sel=01, q1=0x55 next cycle, out_ready=0 -> after 2 edges out_valid=1, out_data=0x55, level=1.
REQ-033 en=1 for 3 consecutive cycles sel=01,10,11 with q1=0xA1,q2=0xB2,q3=0xC3 aligned one cycle later -> pops in order 0xA1,0xB2,0xC3.
REQ-034 DEPTH=8, 9 pushes 0x00..0x08 with out_ready=0 -> full=1, level=8, word 0x08 dropped, drop_cnt=1 when macro defined.
REQ-035 Full buffer, push 0x77 with out_ready=1 same cycle -> level stays 8, 0x77 becomes last word read.
REQ-036 20 pushes interleaved with out_ready=1 every cycle -> pointer wrap exercised, output sequence identical to input sequence.
REQ-037 Assert rst_n low one cycle after en=1 -> no word written, out_valid=0, level=0 after reset release.
